// File: rtl/psa_pipe_if.sv
// psa_pipe_if: operand/result bus of the pipelined subword adder.
//   master : producer/consumer side (drives operands, out_ready, err_clr)
//   slave  : the psa_pipe block
// Handshake: a beat moves across a side when valid && ready are both high
// at a rising clock edge; while valid is high and ready is low the sender
// holds valid and all data stable.
// Signals:
//   in_valid/in_ready  operand beat handshake
//   a, b               W-bit operands, lane i = [i*LANE_W +: LANE_W]
//   sub, sat           subtract select, saturate request
//   out_valid/out_ready result beat handshake
//   sum, lane_ovf, error  result, per-lane overflow, OR of lane_ovf
//   err_sticky, err_clr   sticky error flag and its clear
interface psa_pipe_if #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) ();
  localparam int W = LANES * LANE_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     sum;
  logic [LANES-1:0] lane_ovf;
  logic             error;
  logic             err_sticky;
  logic             err_clr;

  modport master (
    output in_valid, a, b, sub, sat, out_ready, err_clr,
    input  in_ready, out_valid, sum, lane_ovf, error, err_sticky
  );

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready, err_clr,
    output in_ready, out_valid, sum, lane_ovf, error, err_sticky
  );
endinterface

// File: rtl/psa_pipe.sv
// psa_pipe: two-stage pipelined parallel subword adder/subtractor.
// LANES independent signed lanes of LANE_W bits; no carry crosses lanes.
// S1 captures the operands; the lane sums are formed from S1 and latched
// into S2, which drives the result bus.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (discards in-flight beats)
//   bus    psa_pipe_if.slave (operand in, result out, sticky error)
// Build option: define PSA_SAT_EN to build the saturation path; lanes that
// overflow with captured sat=1 then return the signed bound. Without it
// the sat input is ignored and all lanes wrap.
module psa_pipe #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  psa_pipe_if.slave bus
);
  localparam int W = LANES * LANE_W;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic             r_s1_sub;
`ifdef PSA_SAT_EN
  logic             r_s1_sat;
`else
  logic             w_unused_sat;
`endif

  // Stage 2 registers
  logic             r_s2_valid;
  logic [W-1:0]     r_s2_sum;
  logic [LANES-1:0] r_s2_ovf;
  logic             r_err_sticky;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [W-1:0]     w_r;
  logic [W-1:0]     w_s2_d;
  logic [LANES-1:0] w_ovf;

  // A stage may load when it is empty or its content leaves this cycle.
  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_bx;
    logic [LANE_W-1:0] w_low;
    logic [1:0]        w_top;

    assign w_a  = r_s1_a[g*LANE_W +: LANE_W];
    // Subtraction as A + ~B + 1; the +1 enters as carry-in of the low part.
    assign w_bx = r_s1_b[g*LANE_W +: LANE_W] ^ {LANE_W{r_s1_sub}};
    // Low bits summed one bit wide so the carry into the MSB is visible.
    assign w_low = {1'b0, w_a[LANE_W-2:0]} + {1'b0, w_bx[LANE_W-2:0]}
                 + {{(LANE_W-1){1'b0}}, r_s1_sub};
    assign w_top = {1'b0, w_a[LANE_W-1]} + {1'b0, w_bx[LANE_W-1]}
                 + {1'b0, w_low[LANE_W-1]};
    assign w_r[g*LANE_W +: LANE_W] = {w_top[0], w_low[LANE_W-2:0]};
    // Signed overflow: carry into MSB differs from carry out of MSB.
    assign w_ovf[g] = w_low[LANE_W-1] ^ w_top[1];

`ifdef PSA_SAT_EN
    // Overflow direction follows A's sign: positive A -> 011..1, negative -> 100..0.
    assign w_s2_d[g*LANE_W +: LANE_W] = (w_ovf[g] && r_s1_sat)
      ? {w_a[LANE_W-1], {(LANE_W-1){~w_a[LANE_W-1]}}}
      : w_r[g*LANE_W +: LANE_W];
`else
    assign w_s2_d[g*LANE_W +: LANE_W] = w_r[g*LANE_W +: LANE_W];
`endif
  end

`ifndef PSA_SAT_EN
  assign w_unused_sat = bus.sat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_sub     <= 1'b0;
`ifdef PSA_SAT_EN
      r_s1_sat     <= 1'b0;
`endif
      r_s2_valid   <= 1'b0;
      r_s2_sum     <= '0;
      r_s2_ovf     <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_a   <= bus.a;
          r_s1_b   <= bus.b;
          r_s1_sub <= bus.sub;
`ifdef PSA_SAT_EN
          r_s1_sat <= bus.sat;
`endif
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        // Result registers hold their last value while the stage is empty.
        if (r_s1_valid) begin
          r_s2_sum <= w_s2_d;
          r_s2_ovf <= w_ovf;
        end
      end
      // Setting on a taken error beat has priority over the clear.
      if (r_s2_valid && bus.out_ready && (|r_s2_ovf)) begin
        r_err_sticky <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_s1_adv;
  assign bus.out_valid  = r_s2_valid;
  assign bus.sum        = r_s2_sum;
  assign bus.lane_ovf   = r_s2_ovf;
  assign bus.error      = |r_s2_ovf;
  assign bus.err_sticky = r_err_sticky;
endmodule

// File: tb/tb_psa_pipe.sv
module tb_psa_pipe;
  localparam int LANE_W = 4;
  localparam int LANES  = 4;
  localparam int W      = LANES * LANE_W;
`ifdef PSA_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic exp_sticky;
  logic [LANES+W-1:0] exp_q[$];

  psa_pipe_if #(.LANE_W(LANE_W), .LANES(LANES)) bus ();

  psa_pipe #(.LANE_W(LANE_W), .LANES(LANES)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Signed lane arithmetic on plain integers; returns {lane_ovf, sum}.
  function automatic logic [LANES+W-1:0] model(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s,
                                               input logic st);
    logic [W-1:0]     r;
    logic [LANES-1:0] o;
    int sa, sb, res, lo, hi;
    lo = -(1 << (LANE_W-1));
    hi = (1 << (LANE_W-1)) - 1;
    for (int i = 0; i < LANES; i++) begin
      sa  = int'($signed(a[i*LANE_W +: LANE_W]));
      sb  = int'($signed(b[i*LANE_W +: LANE_W]));
      res = s ? (sa - sb) : (sa + sb);
      o[i] = (res > hi) || (res < lo);
      if (SAT_EN && st && res > hi) res = hi;
      if (SAT_EN && st && res < lo) res = lo;
      r[i*LANE_W +: LANE_W] = res[LANE_W-1:0];
    end
    return {o, r};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.sat       = 1'b0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic st);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.sat      = st;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.sum !== '0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
    n_cmp++; if (bus.lane_ovf !== '0) begin n_fail++; $display("FAIL reset_lane_ovf got=%b exp=0", bus.lane_ovf); end
    n_cmp++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky got=%b exp=0", bus.err_sticky); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    exp_sticky = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0]     va[5]   = '{16'h1234, 16'h7000, 16'h8000, 16'h7000, 16'h8000};
    logic [W-1:0]     vb[5]   = '{16'h1111, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
    logic             vs[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic             vt[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0]     vsum[5];
    logic [LANES-1:0] vovf[5] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    vsum[0] = 16'h2345;
    vsum[1] = 16'h8000;
    vsum[2] = 16'h7000;
    vsum[3] = SAT_EN ? 16'h7000 : 16'h8000;
    vsum[4] = SAT_EN ? 16'h8000 : 16'h7000;
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      drive_beat(va[v], vb[v], vs[v], vt[v]);
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got=%b exp=1", v, bus.in_ready); end
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid got=%b exp=0", v, bus.out_valid); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_out_valid got=%b exp=1", v, bus.out_valid); end
      n_cmp++; if (bus.sum !== vsum[v]) begin n_fail++; $display("FAIL dir%0d_sum got=%h exp=%h", v, bus.sum, vsum[v]); end
      n_cmp++; if (bus.lane_ovf !== vovf[v]) begin n_fail++; $display("FAIL dir%0d_lane_ovf got=%b exp=%b", v, bus.lane_ovf, vovf[v]); end
      n_cmp++; if (bus.error !== (|vovf[v])) begin n_fail++; $display("FAIL dir%0d_error got=%b exp=%b", v, bus.error, |vovf[v]); end
      @(posedge clk); @(negedge clk);
      exp_sticky = exp_sticky | (|vovf[v]);
      n_cmp++; if (bus.err_sticky !== exp_sticky) begin n_fail++; $display("FAIL dir%0d_err_sticky got=%b exp=%b", v, bus.err_sticky, exp_sticky); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_drained got=%b exp=0", v, bus.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ba[3];
    logic [W-1:0] bb[3];
    logic         bs[3];
    int idx, got;
    for (int i = 0; i < 3; i++) begin
      ba[i] = W'($urandom); bb[i] = W'($urandom); bs[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; got = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      bus.out_ready = (c >= 4);
      if (idx < 3) drive_beat(ba[idx], bb[idx], bs[idx], 1'b0);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (c == 2 || c == 3) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready c=%0d got=%b exp=0", c, bus.in_ready); end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_result got=%h exp=none", bus.sum);
        end else if ({bus.lane_ovf, bus.sum} !== exp_q[0]) begin
          n_fail++; $display("FAIL bp_result got=%h exp=%h", {bus.lane_ovf, bus.sum}, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        if (bus.error) exp_sticky = 1'b1;
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.sub, 1'b0));
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL bp_count got=%0d exp=3", got); end
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL bp_leftover got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_err_sticky();
    @(posedge clk); #1;
    drive_idle();
    bus.out_ready = 1'b1;
    bus.err_clr   = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_alone got=%b exp=0", bus.err_sticky); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive_beat(16'h7000, 16'h1000, 1'b0, 1'b0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.err_clr   = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_set_valid got=%b exp=1", bus.out_valid); end
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_set_pre got=%b exp=0", bus.err_sticky); end
    @(posedge clk); #1 bus.err_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.err_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins got=%b exp=1", bus.err_sticky); end
    exp_sticky = 1'b1;
  endtask

  task automatic test_random();
    logic acc;
    logic exp_ready;
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!bus.in_valid || acc) begin
        if ($urandom_range(0, 3) != 0)
          drive_beat(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else
          bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      acc = 1'b0;
      @(negedge clk);
      exp_ready = (exp_q.size() < 2) || bus.out_ready;
      n_cmp++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_ready); end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_result c=%0d got=%h exp=none", c, bus.sum);
        end else begin
          if ({bus.lane_ovf, bus.sum} !== exp_q[0] || bus.error !== (|exp_q[0][LANES+W-1:W])) begin
            n_fail++; $display("FAIL rnd_result c=%0d got=%h/%b exp=%h", c, {bus.lane_ovf, bus.sum}, bus.error, exp_q[0]);
          end
          if (|exp_q[0][LANES+W-1:W]) exp_sticky = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.sat));
        acc = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL drain_extra_result got=%h exp=none", bus.sum);
        end else begin
          if ({bus.lane_ovf, bus.sum} !== exp_q[0]) begin
            n_fail++; $display("FAIL drain_result got=%h exp=%h", {bus.lane_ovf, bus.sum}, exp_q[0]);
          end
          if (|exp_q[0][LANES+W-1:W]) exp_sticky = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL drain_leftover got=%0d exp=0", exp_q.size()); end
    n_cmp++; if (bus.err_sticky !== exp_sticky) begin n_fail++; $display("FAIL rnd_err_sticky got=%b exp=%b", bus.err_sticky, exp_sticky); end
    exp_q.delete();
  endtask

  task automatic test_reset_inflight();
    int stale;
    // Make sure the sticky flag is set before reset so clearing is observable.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive_beat(16'h7000, 16'h1000, 1'b0, 1'b0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    drive_beat(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_beat(16'h4321, 16'h0101, 1'b1, 1'b0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.err_sticky !== 1'b1) begin n_fail++; $display("FAIL rst_pre_sticky got=%b exp=1", bus.err_sticky); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_full got=%b exp=0", bus.in_ready); end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_err_sticky got=%b exp=0", bus.err_sticky); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.lane_ovf !== '0) begin n_fail++; $display("FAIL rst_lane_ovf got=%b exp=0", bus.lane_ovf); end
    exp_sticky = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_fail++; $display("FAIL rst_stale_results got=%0d exp=0", stale); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    exp_sticky = 1'b0;
    rst_n      = 1'b0;
    drive_idle();
    test_reset();
    test_directed();
    test_back_to_back();
    test_err_sticky();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
